phase_scheduler: RTL and testbench
==================================

Name: phase_scheduler

Overview:
Sequences the intersection's green phases from latched request sensors and drives the four green outputs consumed by the intersection datapath and its formal checkers. Arbitrates four phases (UP, DOWN, TURN, PED) round-robin. Enforces minimum and maximum green time and an all-red clearance interval between phases. The PED phase grants pedestrian_green together with turn_green.

Parameters:
MIN_GREEN, 4, minimum cycles a granted phase stays green (≥1)
MAX_GREEN, 12, maximum green cycles while the own request is held and others wait (≥ MIN_GREEN)
CLEAR_CYCLES, 2, all-red cycles between two green phases (≥1)
CNT_W, 8, timer width; must hold MAX_GREEN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_up  in  1  up-direction vehicle request (level or pulse)
req_down  in  1  down-direction vehicle request
req_turn  in  1  turn-lane request
req_pedestrian  in  1  pedestrian button
up_green  out  1  UP phase green
down_green  out  1  DOWN phase green
turn_green  out  1  high in TURN or PED phase
pedestrian_green  out  1  PED phase green
all_red  out  1  high in IDLE and CLEAR
active_phase  out  2  current/last phase: 0 UP, 1 DOWN, 2 TURN, 3 PED

Behaviour:
- Clock/reset: one clock, `clock`. `reset` is asynchronous and active-high. All state resets immediately: state=IDLE, pending=0, timer=0, rr pointer so UP has top priority, active_phase=0, all greens 0, all_red=1.
- Cycle convention: cycle n follows the nth rising edge after reset deasserts.
- Request latching: pending[p] is set on any cycle req_p=1, except while phase p is GREEN; such a request is absorbed and only extends that phase.
- pending[p] clears on the edge that enters GREEN(p).
- A request arriving in the same cycle as clear-on-grant is absorbed.
- States:
  - IDLE: all red. If pending != 0, go to GREEN(winner) next edge.
  - GREEN(p): timer counts from 0. Leave to CLEAR when all of these hold:
    - timer ≥ MIN_GREEN-1
    - some other pending bit is set
    - req_p = 0 or timer ≥ MAX_GREEN-1
  - If no other phase is pending, GREEN rests indefinitely and the timer saturates.
  - CLEAR: all greens 0, all_red=1, for exactly CLEAR_CYCLES cycles. Then go to GREEN(winner), or IDLE if pending = 0.
- Arbitration: round-robin over pending, starting one after the last served phase (order UP→DOWN→TURN→PED→UP). The winner is computed from registered pending.
- Outputs are registered and decoded from state; no combinational input→output path.
- Latency: req in cycle t while IDLE → pending in cycle t+1 → green in cycle t+2.
- Invariants (checker-visible):
  - at most one of up_green, down_green, turn_green-without-pedestrian is active
  - pedestrian_green ⇒ turn_green
  - up_green ⇒ !down_green
  - any change of granted phase is separated by ≥ CLEAR_CYCLES all-red cycles
  - green length ≥ MIN_GREEN whenever followed by CLEAR
- Timer wrap: saturates at 2^CNT_W-1 and never wraps.
- Reset mid-GREEN or mid-CLEAR: greens drop asynchronously and pending requests are discarded.

Decomposition:
- Shared package `traffic_pkg`:
  - enum phase_t {PH_UP, PH_DOWN, PH_TURN, PH_PED}
  - enum sched_state_t {S_IDLE, S_GREEN, S_CLEAR}
  - NUM_PHASES=4
- One sub-module: `rr_arbiter4`, a combinational 4-way round-robin pick from (pending, last_phase) → (valid, winner).
- Sequential FSM, timer and pending registers live in phase_scheduler.

Test Plan:
- Reset, req_up pulse cycle 1 → pending cycle 2, up_green=1 from cycle 3, stays high indefinitely, all_red=0.
- Up green resting, req_down pulse cycle 10 → up_green drops cycle 12, all_red cycles 12–13, down_green=1 cycle 14.
- req_up held high, req_down pulsed at up's timer=0 → up_green lasts exactly 12 cycles (MAX_GREEN), 2 red cycles, then down_green.
- All four reqs pulsed together from IDLE → greens in order UP, DOWN, TURN, PED, each 4 cycles with 2 all-red cycles between. During PED, pedestrian_green=1 and turn_green=1. Then IDLE, all_red=1.
- req_up and req_down held continuously plus one req_turn pulse → TURN granted within one rotation (≤ 2×(12+2) cycles); no starvation.
- Assert reset mid-GREEN(DOWN) with req_turn pending → down_green=0 immediately (async), pending cleared. After release with no requests, remain IDLE.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler.
//   phase_t       : the four green phases, encoded as driven on active_phase
//   sched_state_t : scheduler FSM states
//   NUM_PHASES    : number of arbitrated phases
//   phase_onehot  : one-hot request-vector bit for a phase
package traffic_pkg;

  localparam int NUM_PHASES = 4;

  typedef enum logic [1:0] {
    PH_UP   = 2'd0,
    PH_DOWN = 2'd1,
    PH_TURN = 2'd2,
    PH_PED  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GREEN = 2'd1,
    S_CLEAR = 2'd2
  } sched_state_t;

  function automatic logic [NUM_PHASES-1:0] phase_onehot(input phase_t p);
    return NUM_PHASES'(1) << p;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick.
//   pending    : request bits, bit index = phase_t encoding
//   last_phase : most recently served phase; search starts one after it
//   valid      : at least one pending bit set
//   winner     : first pending phase in UP->DOWN->TURN->PED->UP order
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [NUM_PHASES-1:0] pending,
  input  phase_t                last_phase,
  output logic                  valid,
  output phase_t                winner
);

  logic [1:0] idx;

  // Scan from the farthest offset down to the nearest so the closest
  // pending phase after last_phase is the final (winning) assignment.
  always_comb begin
    valid  = 1'b0;
    winner = PH_UP;
    idx    = 2'd0;
    for (int i = NUM_PHASES; i >= 1; i--) begin
      idx = 2'(int'(last_phase) + i);
      if (pending[idx]) begin
        valid  = 1'b1;
        winner = phase_t'(idx);
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Green-phase sequencer for the intersection.
// Latches requests, arbitrates round-robin, enforces min/max green and an
// all-red clearance interval, and drives registered green outputs.
//   clock, reset       : rising-edge clock, async active-high reset
//   req_*              : phase requests (level or pulse)
//   up/down/turn_green : phase greens (turn_green also high in PED)
//   pedestrian_green   : PED phase green
//   all_red            : high in IDLE and CLEAR
//   active_phase       : current / last granted phase
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 12,
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       req_turn,
  input  logic       req_pedestrian,
  output logic       up_green,
  output logic       down_green,
  output logic       turn_green,
  output logic       pedestrian_green,
  output logic       all_red,
  output logic [1:0] active_phase
);

  sched_state_t            state_reg;
  phase_t                  phase_reg;
  phase_t                  last_reg;
  logic [NUM_PHASES-1:0]   pending_reg;
  logic [CNT_W-1:0]        timer_reg;

  logic [NUM_PHASES-1:0]   req_vec;
  logic [NUM_PHASES-1:0]   green_mask;
  logic [NUM_PHASES-1:0]   pending_set;
  logic [CNT_W-1:0]        timer_inc;
  logic                    arb_valid;
  phase_t                  arb_winner;
  logic                    other_pending;
  logic                    at_min;
  logic                    at_max;
  logic                    leave_green;
  logic                    clear_done;
  logic                    start_green;

  assign req_vec = {req_pedestrian, req_turn, req_down, req_up};

  // A request for the phase currently green only extends it; it is not latched.
  assign green_mask  = (state_reg == S_GREEN) ? phase_onehot(phase_reg) : '0;
  assign pending_set = req_vec & ~green_mask;

  rr_arbiter4 u_arb (
    .pending    (pending_reg),
    .last_phase (last_reg),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign timer_inc     = (&timer_reg) ? timer_reg : timer_reg + 1'b1;
  assign other_pending = |(pending_reg & ~phase_onehot(phase_reg));
  assign at_min        = timer_reg >= CNT_W'(MIN_GREEN - 1);
  assign at_max        = timer_reg >= CNT_W'(MAX_GREEN - 1);
  assign leave_green   = at_min && other_pending && (!req_vec[phase_reg] || at_max);
  assign clear_done    = timer_reg >= CNT_W'(CLEAR_CYCLES - 1);
  assign start_green   = arb_valid &&
                         ((state_reg == S_IDLE) || (state_reg == S_CLEAR && clear_done));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      phase_reg        <= PH_UP;
      last_reg         <= PH_PED;  // UP is searched first after reset
      pending_reg      <= '0;
      timer_reg        <= '0;
      up_green         <= 1'b0;
      down_green       <= 1'b0;
      turn_green       <= 1'b0;
      pedestrian_green <= 1'b0;
      all_red          <= 1'b1;
      active_phase     <= 2'd0;
    end else begin
      // Granted bit is cleared after the OR so a same-cycle request is absorbed.
      if (start_green)
        pending_reg <= (pending_reg | pending_set) & ~phase_onehot(arb_winner);
      else
        pending_reg <= pending_reg | pending_set;

      case (state_reg)
        S_IDLE, S_CLEAR: begin
          if (start_green) begin
            state_reg        <= S_GREEN;
            phase_reg        <= arb_winner;
            last_reg         <= arb_winner;
            timer_reg        <= '0;
            up_green         <= (arb_winner == PH_UP);
            down_green       <= (arb_winner == PH_DOWN);
            turn_green       <= (arb_winner == PH_TURN) || (arb_winner == PH_PED);
            pedestrian_green <= (arb_winner == PH_PED);
            all_red          <= 1'b0;
            active_phase     <= arb_winner;
          end else if (state_reg == S_CLEAR && clear_done) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
          end else if (state_reg == S_CLEAR) begin
            timer_reg <= timer_inc;
          end
        end
        S_GREEN: begin
          if (leave_green) begin
            state_reg        <= S_CLEAR;
            timer_reg        <= '0;
            up_green         <= 1'b0;
            down_green       <= 1'b0;
            turn_green       <= 1'b0;
            pedestrian_green <= 1'b0;
            all_red          <= 1'b1;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
module tb_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int CLR   = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_up = 1'b0, req_down = 1'b0, req_turn = 1'b0, req_pedestrian = 1'b0;
  logic       up_green, down_green, turn_green, pedestrian_green, all_red;
  logic [1:0] active_phase;

  phase_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .CLEAR_CYCLES(CLR), .CNT_W(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_up           (req_up),
    .req_down         (req_down),
    .req_turn         (req_turn),
    .req_pedestrian   (req_pedestrian),
    .up_green         (up_green),
    .down_green       (down_green),
    .turn_green       (turn_green),
    .pedestrian_green (pedestrian_green),
    .all_red          (all_red),
    .active_phase     (active_phase)
  );

  always #5 clock = ~clock;

  // Scoreboard entry: expected phase of the next grant and its green length
  // (0 = grant still resting when the step ends, length not checked).
  typedef struct {
    int ph;
    int len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   prev_valid = 0;
  int   prev_grant = 0;
  bit   seen_grant = 0;
  int   green_len = 0;
  int   red_len = 0;
  int   exp_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int ph, input int len);
    exp_t e;
    e.ph  = ph;
    e.len = len;
    sb.push_back(e);
  endtask

  // Per-cycle monitor: invariants, grant order/length and clearance length.
  task automatic monitor();
    bit   v;
    int   g;
    exp_t e;
    v = up_green | down_green | turn_green;
    if (pedestrian_green)  g = 3;
    else if (turn_green)   g = 2;
    else if (down_green)   g = 1;
    else                   g = 0;
    chk("all_red_vs_greens", all_red, !v);
    if (pedestrian_green) chk("ped_implies_turn", turn_green, 1);
    if (up_green)   chk("up_exclusive", down_green | turn_green, 0);
    if (down_green) chk("down_exclusive", turn_green, 0);
    if (v && prev_valid) chk("no_switch_without_clear", g, prev_grant);
    if (v && !prev_valid) begin
      if (seen_grant) chk("clear_len", red_len, CLR);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_grant observed=%0d expected=none (cycle %0d)", g, cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("grant_phase", g, e.ph);
        exp_len = e.len;
      end else begin
        exp_len = 0;
      end
      chk("active_phase", active_phase, g);
      green_len  = 0;
      seen_grant = 1;
      $display("cycle %0d: grant phase %0d", cyc, g);
    end
    if (v) green_len++;
    if (!v && prev_valid) begin
      if (exp_len != 0) chk("green_len", green_len, exp_len);
      $display("cycle %0d: phase %0d ended after %0d green cycles", cyc, prev_grant, green_len);
      red_len = 0;
    end
    if (!v) red_len++;
    prev_valid = v;
    prev_grant = g;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_up = 0; req_down = 0; req_turn = 0; req_pedestrian = 0;
    sb.delete();
    prev_valid = 0;
    seen_grant = 0;
    green_len  = 0;
    red_len    = 0;
    exp_len    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_up"},   up_green, 0);
    chk({tag, "_down"}, down_green, 0);
    chk({tag, "_turn"}, turn_green, 0);
    chk({tag, "_ped"},  pedestrian_green, 0);
    chk({tag, "_red"},  all_red, 1);
    chk({tag, "_ap"},   active_phase, 0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic full_reset();
    apply_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    release_reset();
  endtask

  initial begin
    int waited;

    // 1: single UP request, then DOWN takes over from a resting UP.
    full_reset();
    tick();                       // cycle 1
    req_up = 1; push(0, 9);
    tick(); req_up = 0;           // cycle 2
    chk("s1_up_c2", up_green, 0);
    chk("s1_red_c2", all_red, 1);
    tick();                       // cycle 3
    chk("s1_up_c3", up_green, 1);
    chk("s1_red_c3", all_red, 0);
    repeat (7) tick();            // cycle 10
    chk("s1_up_rest", up_green, 1);
    req_down = 1; push(1, 0);
    tick(); req_down = 0;         // cycle 11
    chk("s1_up_c11", up_green, 1);
    tick();                       // cycle 12
    chk("s1_up_c12", up_green, 0);
    chk("s1_red_c12", all_red, 1);
    tick();                       // cycle 13
    chk("s1_red_c13", all_red, 1);
    tick();                       // cycle 14
    chk("s1_down_c14", down_green, 1);
    repeat (5) tick();
    chk("s1_sb_drained", sb.size(), 0);

    // 2: held UP is cut at MAX_GREEN by a waiting DOWN.
    full_reset();
    tick();                       // cycle 1
    req_up = 1; push(0, MAX_G);
    repeat (2) tick();            // cycle 3
    chk("s2_up_c3", up_green, 1);
    req_down = 1; push(1, 0);
    tick(); req_down = 0;         // cycle 4
    repeat (10) tick();           // cycle 14
    chk("s2_up_c14", up_green, 1);
    req_up = 0;
    tick();                       // cycle 15
    chk("s2_up_c15", up_green, 0);
    tick();                       // cycle 16
    chk("s2_red_c16", all_red, 1);
    tick();                       // cycle 17
    chk("s2_down_c17", down_green, 1);
    repeat (3) tick();
    chk("s2_sb_drained", sb.size(), 0);

    // 3: all four requests at once are served in rotation order.
    full_reset();
    tick();                       // cycle 1
    req_up = 1; req_down = 1; req_turn = 1; req_pedestrian = 1;
    push(0, MIN_G); push(1, MIN_G); push(2, MIN_G); push(3, 0);
    tick();                       // cycle 2
    req_up = 0; req_down = 0; req_turn = 0; req_pedestrian = 0;
    repeat (19) tick();           // cycle 21
    chk("s3_ped_c21", pedestrian_green, 1);
    chk("s3_turn_c21", turn_green, 1);
    chk("s3_ap_c21", active_phase, 3);
    repeat (8) tick();            // cycle 29: PED rests with nothing else pending
    chk("s3_ped_rest", pedestrian_green, 1);
    chk("s3_sb_drained", sb.size(), 0);

    // 4: UP and DOWN held, a single TURN pulse must still be served.
    full_reset();
    tick();                       // cycle 1
    req_up = 1; req_down = 1; req_turn = 1;
    push(0, MAX_G); push(1, MAX_G); push(2, MIN_G); push(0, 0);
    tick(); req_turn = 0;         // cycle 2
    waited = 0;
    while (!turn_green && waited < 40) begin
      tick();
      waited++;
    end
    chk("s4_turn_granted", turn_green, 1);
    chk("s4_turn_cycle", cyc, 31);
    repeat (6) tick();            // cycle 37
    chk("s4_up_again", up_green, 1);
    chk("s4_sb_drained", sb.size(), 0);
    req_up = 0; req_down = 0;

    // 5: reset mid-GREEN(DOWN) with TURN pending drops greens immediately.
    full_reset();
    tick();                       // cycle 1
    req_down = 1; push(1, 0);
    tick(); req_down = 0;         // cycle 2
    tick();                       // cycle 3
    chk("s5_down_c3", down_green, 1);
    req_turn = 1;
    tick(); req_turn = 0;         // cycle 4
    tick();                       // cycle 5
    chk("s5_down_c5", down_green, 1);
    apply_reset();
    #1;
    check_reset_outputs("s5_async");
    release_reset();
    repeat (10) tick();
    chk("s5_idle_red", all_red, 1);
    chk("s5_idle_turn", turn_green, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
